// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART frame receiver and its bit timer.
package uart_pkg;

   localparam int MSG_BITS_DEFAULT     = 20;
   localparam int CLKS_PER_BIT_DEFAULT = 10;
   localparam int FRAME_BITS           = MSG_BITS_DEFAULT + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver with mid-bit and end-of-bit strobes.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int MID_COUNT    = CLKS_PER_BIT_DEFAULT / 2 - 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic mid_strobe,
   output logic end_strobe
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] MID  = TW'(MID_COUNT);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + TW'(1);
      end
   end

   assign mid_strobe = (count == MID);
   assign end_strobe = (count == LAST);

endmodule

// File: rtl/uart_frame_receiver.sv
// UART frame receiver: start bit, MSG_BITS payload LSB first, stop bit.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_frame_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int MSG_BITS     = MSG_BITS_DEFAULT
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                serialIn,
   input  logic                ack,
   output logic [MSG_BITS-1:0] message,
   output logic                valid,
   output logic                framingError,
   output logic                overrun
);

   localparam int CW = $clog2(MSG_BITS + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(MSG_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam int MID_COUNT = CLKS_PER_BIT / 2;
`else
   localparam int MID_COUNT = CLKS_PER_BIT / 2 - 1;
`endif

   rx_state_t           state;
   logic                sync_meta;
   logic                rxs;
   logic                rxs_prev;
   logic                sample_bit;
   logic                timer_clear;
   logic                mid_strobe;
   logic                end_strobe;
   logic [CW-1:0]       bit_count;
   logic [MSG_BITS-1:0] shift;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b1;
         rxs       <= 1'b1;
         rxs_prev  <= 1'b1;
      end else begin
         sync_meta <= serialIn;
         rxs       <= sync_meta;
         rxs_prev  <= rxs;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic rxs_prev2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rxs_prev2 <= 1'b1;
      end else begin
         rxs_prev2 <= rxs_prev;
      end
   end

   // Decision taken one clock after mid-bit, voting over mid-1, mid, mid+1.
   assign sample_bit = maj3(rxs_prev2, rxs_prev, rxs);
`else
   assign sample_bit = rxs;
`endif

   // Clearing at the start-bit decision aligns every later decision with end_strobe.
   always_comb begin
      timer_clear = 1'b0;
      if (state == IDLE) begin
         timer_clear = 1'b1;
      end else if ((state == START) && mid_strobe) begin
         timer_clear = 1'b1;
      end
   end

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .MID_COUNT    (MID_COUNT)
   ) u_bit_timer (
      .clock      (clock),
      .reset      (reset),
      .clear      (timer_clear),
      .mid_strobe (mid_strobe),
      .end_strobe (end_strobe)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         bit_count    <= '0;
         shift        <= '0;
         message      <= '0;
         valid        <= 1'b0;
         framingError <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         framingError <= 1'b0;
         overrun      <= 1'b0;
         if (ack && valid) begin
            valid <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (rxs_prev && !rxs) begin
                  state <= START;
               end
            end
            START: begin
               if (mid_strobe) begin
                  bit_count <= '0;
                  state     <= sample_bit ? IDLE : DATA;
               end
            end
            DATA: begin
               if (end_strobe) begin
                  shift     <= {sample_bit, shift[MSG_BITS-1:1]};
                  bit_count <= bit_count + CW'(1);
                  if (bit_count == LAST_BIT) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (end_strobe) begin
                  state <= IDLE;
                  if (!sample_bit) begin
                     framingError <= 1'b1;
                  end else if (!valid || ack) begin
                     message <= shift;
                     valid   <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
